// File: rtl/alu_exec_if.sv
// Handshake bundle between the ALU decoder, the execute ALU and its consumer.
// The master modport is the side that issues operations and consumes results.
interface alu_exec_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [2:0]      alu_control;
  logic [2:0]      funct3;
  logic            funct7_5;
  logic [XLEN-1:0] src_a;
  logic [XLEN-1:0] src_b;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            zero;
  logic            busy;

  modport master (
    output in_valid, alu_control, funct3, funct7_5, src_a, src_b, out_ready,
    input  in_ready, out_valid, result, zero, busy
  );

  modport slave (
    input  in_valid, alu_control, funct3, funct7_5, src_a, src_b, out_ready,
    output in_ready, out_valid, result, zero, busy
  );
endinterface

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: single-cycle arithmetic/logic ops and an iterative
// shifter (SHIFT_STEP bits per cycle), with valid/ready on both sides.
module alu_exec_unit #(
  parameter int XLEN       = 32,
  parameter int SHIFT_STEP = 1
) (
  input  logic       clk,
  input  logic       reset,
  alu_exec_if.slave  alu_bus
);

  localparam int SHW = $clog2(XLEN);
  localparam logic [SHW:0] STEP = (SHW+1)'(SHIFT_STEP);

  localparam logic [2:0] OP_ADD   = 3'b000;
  localparam logic [2:0] OP_SUB   = 3'b001;
  localparam logic [2:0] OP_AND   = 3'b010;
  localparam logic [2:0] OP_OR    = 3'b011;
  localparam logic [2:0] OP_XOR   = 3'b100;
  localparam logic [2:0] OP_SLT   = 3'b101;
  localparam logic [2:0] OP_SLTU  = 3'b110;
  localparam logic [2:0] OP_SHIFT = 3'b111;

  // One-hot so out_valid and busy come straight off a state flop.
  typedef enum logic [2:0] {
    IDLE  = 3'b001,
    SHIFT = 3'b010,
    DONE  = 3'b100
  } state_t;

  typedef enum logic [1:0] {
    K_SLL = 2'b00,
    K_SRL = 2'b01,
    K_SRA = 2'b10
  } shift_kind_t;

  function automatic logic [XLEN-1:0] alu_calc(
    input logic [2:0]      ctrl,
    input logic [XLEN-1:0] a,
    input logic [XLEN-1:0] b
  );
    logic signed [XLEN-1:0] sa;
    logic signed [XLEN-1:0] sb;
    logic [XLEN-1:0]        r;
    sa = a;
    sb = b;
    unique case (ctrl)
      OP_ADD:  r = a + b;
      OP_SUB:  r = a - b;
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      OP_SLT:  r = {{(XLEN-1){1'b0}}, (sa < sb)};
      OP_SLTU: r = {{(XLEN-1){1'b0}}, (a < b)};
      default: r = a;  // shift by zero passes src_a through
    endcase
    return r;
  endfunction

  function automatic logic [XLEN-1:0] shift_by(
    input shift_kind_t     kind,
    input logic [XLEN-1:0] v,
    input logic [SHW:0]    amt
  );
    logic signed [XLEN-1:0] sv;
    logic [XLEN-1:0]        r;
    sv = v;
    unique case (kind)
      K_SLL:   r = v << amt;
      K_SRA:   r = $unsigned(sv >>> amt);
      default: r = v >> amt;
    endcase
    return r;
  endfunction

  state_t          state;
  state_t          state_nxt;
  logic            in_ready_c;
  logic            accept;
  logic            start_shift;
  logic [SHW:0]    shamt;
  shift_kind_t     kind_in;
  logic [XLEN-1:0] alu_res;
  logic [SHW:0]    step_amt;
  logic [XLEN-1:0] work_shifted;
  logic            last_step;

  logic [XLEN-1:0] work_p1;
  logic [SHW:0]    cnt_p1;
  shift_kind_t     kind_p1;
  logic [XLEN-1:0] result_p1;
  logic            zero_p1;

  assign accept      = alu_bus.in_valid & in_ready_c;
  assign shamt       = {1'b0, alu_bus.src_b[SHW-1:0]};
  assign start_shift = (alu_bus.alu_control == OP_SHIFT) && (shamt != '0);
  assign kind_in     = (alu_bus.funct3 == 3'b001) ? K_SLL :
                       (alu_bus.funct7_5 ? K_SRA : K_SRL);
  assign alu_res     = alu_calc(alu_bus.alu_control, alu_bus.src_a, alu_bus.src_b);

  assign step_amt     = (cnt_p1 < STEP) ? cnt_p1 : STEP;
  assign work_shifted = shift_by(kind_p1, work_p1, step_amt);
  assign last_step    = (cnt_p1 == step_amt);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (accept) state_nxt = start_shift ? SHIFT : DONE;
      end
      SHIFT: begin
        if (last_step) state_nxt = DONE;
      end
      DONE: begin
        if (accept)                 state_nxt = start_shift ? SHIFT : DONE;
        else if (alu_bus.out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready_c = 1'b0;
    if (!reset) begin
      in_ready_c = (state == IDLE) || ((state == DONE) && alu_bus.out_ready);
    end
    alu_bus.in_ready  = in_ready_c;
    alu_bus.busy      = (state == SHIFT);
    alu_bus.out_valid = (state == DONE);
  end

  // p1: operand capture at accept, iterative shift, result/zero register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      work_p1   <= '0;
      cnt_p1    <= '0;
      kind_p1   <= K_SLL;
      result_p1 <= '0;
      zero_p1   <= 1'b1;
    end else if (accept) begin
      if (start_shift) begin
        work_p1 <= alu_bus.src_a;
        cnt_p1  <= shamt;
        kind_p1 <= kind_in;
      end else begin
        result_p1 <= alu_res;
        zero_p1   <= (alu_res == '0);
      end
    end else if (state == SHIFT) begin
      work_p1 <= work_shifted;
      cnt_p1  <= cnt_p1 - step_amt;
      if (last_step) begin
        result_p1 <= work_shifted;
        zero_p1   <= (work_shifted == '0);
      end
    end
  end

  assign alu_bus.result = result_p1;
  assign alu_bus.zero   = zero_p1;

endmodule
